// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage RV32IM pipeline.
//   Selects ALU operands, computes RV32I ALU ops, single-cycle MUL/MULH*,
//   and 32-iteration restoring DIV/DIVU/REM/REMU. Holds the EX/MEM register.
// Ports:
//   clk_ex, rst_ex            clock, synchronous active-high reset
//   valid_ex, flush_ex        ID/EX holds a real op / kill the current EX op
//   pc_ex, pc_next_ex         operand A source / PC+4 passed through
//   RU_rs1_ex, RU_rs2_ex      forwarded register values (rs2 also store data)
//   imm_ex                    sign-extended immediate (operand B source)
//   alu_a_src_ex, alu_b_src_ex  operand selects (A: 0=rs1 1=pc, B: 0=rs2 1=imm)
//   alu_op_ex, rd_ex          operation code, destination register
//   dm_ctrl_ex, RU_DM_write_src_ex, RUwrite_ex, dm_wr_ex  control passed to MEM
//   busy_ex                   combinational stall request while dividing
//   *_me                      EX/MEM pipeline register outputs
module execute_stage #(
  parameter int DIV_EN = 1
) (
  input  logic        clk_ex,
  input  logic        rst_ex,
  input  logic        valid_ex,
  input  logic        flush_ex,
  input  logic [31:0] pc_ex,
  input  logic [31:0] pc_next_ex,
  input  logic [31:0] RU_rs1_ex,
  input  logic [31:0] RU_rs2_ex,
  input  logic [31:0] imm_ex,
  input  logic        alu_a_src_ex,
  input  logic        alu_b_src_ex,
  input  logic [4:0]  alu_op_ex,
  input  logic [4:0]  rd_ex,
  input  logic [2:0]  dm_ctrl_ex,
  input  logic [1:0]  RU_DM_write_src_ex,
  input  logic        RUwrite_ex,
  input  logic        dm_wr_ex,
  output logic        busy_ex,
  output logic [31:0] pc_next_me,
  output logic [31:0] ALU_res_me,
  output logic [31:0] RU_rs2_me,
  output logic [4:0]  rd_me,
  output logic [2:0]  dm_ctrl_me,
  output logic [1:0]  RU_DM_write_src_me,
  output logic        RUwrite_me,
  output logic        dm_wr_me
);

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_PASSB  = 5'd10,
    OP_MUL    = 5'd11,
    OP_MULH   = 5'd12,
    OP_MULHSU = 5'd13,
    OP_MULHU  = 5'd14,
    OP_DIV    = 5'd15,
    OP_DIVU   = 5'd16,
    OP_REM    = 5'd17,
    OP_REMU   = 5'd18
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } div_state_t;

  div_state_t  state;

  logic [31:0] op_a, op_b;
  logic [31:0] alu_res;
  logic [63:0] prod_ss, prod_su, prod_uu;

  logic        is_div_op, div_signed, is_rem_op;
  logic        div_start, bubble;
  logic        a_neg, b_neg, div_by_zero, div_ovf;
  logic [31:0] a_mag, b_mag;

  logic [31:0] div_rem, div_quo, div_den;
  logic [4:0]  div_cnt;
  logic        q_neg, r_neg, want_rem;
  logic [32:0] rem_sh, diff;
  logic [31:0] rem_next, quo_next, div_result;

  always_comb begin
    op_a = alu_a_src_ex ? pc_ex  : RU_rs1_ex;
    op_b = alu_b_src_ex ? imm_ex : RU_rs2_ex;
  end

  // Products are formed as 64x64 unsigned multiplies of suitably extended
  // operands; the low 64 bits are exact for every signedness combination.
  always_comb begin
    prod_ss = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
    prod_su = {{32{op_a[31]}}, op_a} * {32'd0, op_b};
    prod_uu = {32'd0, op_a} * {32'd0, op_b};
  end

  always_comb begin
    alu_res = '0;
    case (alu_op_ex)
      OP_ADD:    alu_res = op_a + op_b;
      OP_SUB:    alu_res = op_a - op_b;
      OP_SLL:    alu_res = op_a << op_b[4:0];
      OP_SLT:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      OP_SLTU:   alu_res = {31'd0, op_a < op_b};
      OP_XOR:    alu_res = op_a ^ op_b;
      OP_SRL:    alu_res = op_a >> op_b[4:0];
      OP_SRA:    alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      OP_OR:     alu_res = op_a | op_b;
      OP_AND:    alu_res = op_a & op_b;
      OP_PASSB:  alu_res = op_b;
      OP_MUL:    alu_res = prod_uu[31:0];
      OP_MULH:   alu_res = prod_ss[63:32];
      OP_MULHSU: alu_res = prod_su[63:32];
      OP_MULHU:  alu_res = prod_uu[63:32];
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    is_div_op   = (alu_op_ex == OP_DIV) || (alu_op_ex == OP_DIVU) ||
                  (alu_op_ex == OP_REM) || (alu_op_ex == OP_REMU);
    div_signed  = (alu_op_ex == OP_DIV) || (alu_op_ex == OP_REM);
    is_rem_op   = (alu_op_ex == OP_REM) || (alu_op_ex == OP_REMU);
    a_neg       = div_signed & op_a[31];
    b_neg       = div_signed & op_b[31];
    a_mag       = a_neg ? -op_a : op_a;
    b_mag       = b_neg ? -op_b : op_b;
    div_by_zero = (op_b == '0);
    div_ovf     = div_signed && (op_a == 32'h8000_0000) && (op_b == '1);
    div_start   = (DIV_EN != 0) && (state == S_IDLE) && valid_ex && !flush_ex && is_div_op;
    busy_ex     = div_start || (state == S_DIV);
    bubble      = !valid_ex || flush_ex || busy_ex;
  end

  // Restoring step: shift the next dividend bit into the partial remainder
  // and keep the subtraction only when it does not go negative.
  always_comb begin
    rem_sh     = {div_rem, div_quo[31]};
    diff       = rem_sh - {1'b0, div_den};
    rem_next   = diff[32] ? rem_sh[31:0] : diff[31:0];
    quo_next   = {div_quo[30:0], ~diff[32]};
    div_result = want_rem ? (r_neg ? -div_rem : div_rem)
                          : (q_neg ? -div_quo : div_quo);
  end

  // Shortcut cases preload the final quotient/remainder with signs cleared,
  // so DONE applies the same sign-correction path to every divide.
  always_ff @(posedge clk_ex) begin
    if (rst_ex) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      div_rem  <= '0;
      div_quo  <= '0;
      div_den  <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      want_rem <= 1'b0;
    end else if (flush_ex) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (div_start) begin
            want_rem <= is_rem_op;
            div_cnt  <= '0;
            div_den  <= b_mag;
            if (div_by_zero) begin
              div_quo <= '1;
              div_rem <= op_a;
              q_neg   <= 1'b0;
              r_neg   <= 1'b0;
              state   <= S_DONE;
            end else if (div_ovf) begin
              div_quo <= 32'h8000_0000;
              div_rem <= '0;
              q_neg   <= 1'b0;
              r_neg   <= 1'b0;
              state   <= S_DONE;
            end else begin
              div_quo <= a_mag;
              div_rem <= '0;
              q_neg   <= a_neg ^ b_neg;
              r_neg   <= a_neg;
              state   <= S_DIV;
            end
          end
        end
        S_DIV: begin
          div_rem <= rem_next;
          div_quo <= quo_next;
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == 5'd31) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_ex) begin
    if (rst_ex) begin
      pc_next_me         <= '0;
      ALU_res_me         <= '0;
      RU_rs2_me          <= '0;
      rd_me              <= '0;
      dm_ctrl_me         <= '0;
      RU_DM_write_src_me <= '0;
      RUwrite_me         <= 1'b0;
      dm_wr_me           <= 1'b0;
    end else begin
      pc_next_me         <= pc_next_ex;
      ALU_res_me         <= (state == S_DONE) ? div_result : alu_res;
      RU_rs2_me          <= RU_rs2_ex;
      rd_me              <= rd_ex;
      dm_ctrl_me         <= dm_ctrl_ex;
      RU_DM_write_src_me <= RU_DM_write_src_ex;
      RUwrite_me         <= RUwrite_ex & ~bubble;
      dm_wr_me           <= dm_wr_ex & ~bubble;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: self-checking bench for execute_stage.
//   A behavioural model (plain arithmetic plus a busy-cycle countdown) predicts
//   busy_ex and the EX/MEM register every cycle; directed cases pin literals.
module tb_execute_stage;

  logic        clk_ex = 1'b0;
  logic        rst_ex, valid_ex, flush_ex;
  logic [31:0] pc_ex, pc_next_ex, RU_rs1_ex, RU_rs2_ex, imm_ex;
  logic        alu_a_src_ex, alu_b_src_ex;
  logic [4:0]  alu_op_ex, rd_ex;
  logic [2:0]  dm_ctrl_ex;
  logic [1:0]  RU_DM_write_src_ex;
  logic        RUwrite_ex, dm_wr_ex;
  logic        busy_ex;
  logic [31:0] pc_next_me, ALU_res_me, RU_rs2_me;
  logic [4:0]  rd_me;
  logic [2:0]  dm_ctrl_me;
  logic [1:0]  RU_DM_write_src_me;
  logic        RUwrite_me, dm_wr_me;

  execute_stage #(.DIV_EN(1)) dut (
    .clk_ex(clk_ex), .rst_ex(rst_ex), .valid_ex(valid_ex), .flush_ex(flush_ex),
    .pc_ex(pc_ex), .pc_next_ex(pc_next_ex), .RU_rs1_ex(RU_rs1_ex), .RU_rs2_ex(RU_rs2_ex),
    .imm_ex(imm_ex), .alu_a_src_ex(alu_a_src_ex), .alu_b_src_ex(alu_b_src_ex),
    .alu_op_ex(alu_op_ex), .rd_ex(rd_ex), .dm_ctrl_ex(dm_ctrl_ex),
    .RU_DM_write_src_ex(RU_DM_write_src_ex), .RUwrite_ex(RUwrite_ex), .dm_wr_ex(dm_wr_ex),
    .busy_ex(busy_ex), .pc_next_me(pc_next_me), .ALU_res_me(ALU_res_me),
    .RU_rs2_me(RU_rs2_me), .rd_me(rd_me), .dm_ctrl_me(dm_ctrl_me),
    .RU_DM_write_src_me(RU_DM_write_src_me), .RUwrite_me(RUwrite_me), .dm_wr_me(dm_wr_me)
  );

  always #5 clk_ex = ~clk_ex;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model state: a divide in flight is just "busy for m_len cycles, then capture".
  bit          m_active = 0;
  int          m_count = 0;
  int          m_len = 0;
  logic [31:0] m_res = '0;
  bit          m_prev_busy = 0;
  bit          prev_flush = 0;
  bit          last_cap = 0;
  bit          a_busy = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_div(input logic [4:0] op);
    return (op >= 5'd15) && (op <= 5'd18);
  endfunction

  function automatic bit div_short(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || ((op == 5'd15 || op == 5'd17) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    ia = a;
    ib = b;
    if (b == 0) return (op == 5'd15 || op == 5'd16) ? 32'hFFFF_FFFF : a;
    if ((op == 5'd15 || op == 5'd17) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (op == 5'd15) ? 32'h8000_0000 : 32'h0;
    case (op)
      5'd15:   return ia / ib;
      5'd16:   return a / b;
      5'd17:   return ia % ib;
      default: return a % b;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> b[4:0];
      5'd7:  begin p = sa >>> b[4:0]; return p[31:0]; end
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: return b;
      5'd11: return a * b;
      5'd12: begin p = sa * sb; pu = p; return pu[63:32]; end
      5'd13: begin p = sa * longint'({32'd0, b}); pu = p; return pu[63:32]; end
      5'd14: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      5'd15, 5'd16, 5'd17, 5'd18: return ref_div(op, a, b);
      default: return 32'd0;
    endcase
  endfunction

  // One clock cycle: inputs are already applied (at the falling edge).
  task automatic tick();
    logic [31:0] a, b, exp_res;
    bit          exp_busy, bubble;
    logic [31:0] s_pcn, s_rs2;
    logic [4:0]  s_rd;
    logic [2:0]  s_dm;
    logic [1:0]  s_src;
    logic        s_ruw, s_dmw;
    bit          s_rst;
    #1;
    a = alu_a_src_ex ? pc_ex : RU_rs1_ex;
    b = alu_b_src_ex ? imm_ex : RU_rs2_ex;
    exp_busy = 0;
    bubble = 1;
    exp_res = '0;
    s_rst = rst_ex;
    if (rst_ex) begin
      m_active = 0;
    end else if (m_active) begin
      if (m_count < m_len) begin
        exp_busy = 1;
        m_count++;
      end else begin
        m_active = 0;
        if (valid_ex && !flush_ex) begin
          bubble = 0;
          exp_res = m_res;
        end
      end
      if (flush_ex) m_active = 0;
    end else if (valid_ex && !flush_ex) begin
      if (is_div(alu_op_ex)) begin
        exp_busy = 1;
        m_active = 1;
        m_count = 1;
        m_len = div_short(alu_op_ex, a, b) ? 1 : 33;
        m_res = ref_div(alu_op_ex, a, b);
      end else begin
        bubble = 0;
        exp_res = ref_alu(alu_op_ex, a, b);
      end
    end
    a_busy = busy_ex;
    if (!s_rst) check("busy_ex", busy_ex, exp_busy);
    s_pcn = pc_next_ex; s_rs2 = RU_rs2_ex; s_rd = rd_ex; s_dm = dm_ctrl_ex;
    s_src = RU_DM_write_src_ex; s_ruw = RUwrite_ex; s_dmw = dm_wr_ex;
    @(posedge clk_ex);
    #1;
    if (s_rst)
      check("reset_exmem", {pc_next_me, ALU_res_me, RU_rs2_me, rd_me, dm_ctrl_me,
                            RU_DM_write_src_me, RUwrite_me, dm_wr_me}, '0);
    else if (bubble)
      check("bubble_wr", {RUwrite_me, dm_wr_me}, 2'b00);
    else
      check("exmem", {pc_next_me, ALU_res_me, RU_rs2_me, rd_me, dm_ctrl_me,
                      RU_DM_write_src_me, RUwrite_me, dm_wr_me},
                     {s_pcn, exp_res, s_rs2, s_rd, s_dm, s_src, s_ruw, s_dmw});
    last_cap = !s_rst && !bubble;
    last_res = ALU_res_me;
    m_prev_busy = exp_busy;
    prev_flush = flush_ex;
    cyc++;
    @(negedge clk_ex);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_side();
    pc_ex = $urandom; pc_next_ex = $urandom; rd_ex = 5'($urandom);
    dm_ctrl_ex = 3'($urandom); RU_DM_write_src_ex = 2'($urandom); dm_wr_ex = 1'($urandom);
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit b_imm, output logic [31:0] res, output int busy_cnt, output int lat);
    int t0;
    bit done;
    rand_side();
    valid_ex = 1; flush_ex = 0; RUwrite_ex = 1;
    alu_op_ex = op; alu_a_src_ex = 0; RU_rs1_ex = a; alu_b_src_ex = b_imm;
    if (b_imm) begin imm_ex = b; RU_rs2_ex = $urandom; end
    else begin RU_rs2_ex = b; imm_ex = $urandom; end
    t0 = cyc; busy_cnt = 0; done = 0; res = '0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      if (a_busy) busy_cnt++;
      if (last_cap) begin done = 1; res = last_res; end
    end
    lat = cyc - t0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL issue_timeout: op %0d got no capture, required one within 60 cycles", op);
    end
    valid_ex = 0;
  endtask

  initial begin
    logic [31:0] res;
    int bc, lat;
    rst_ex = 1; valid_ex = 0; flush_ex = 0; pc_ex = '0; pc_next_ex = '0;
    RU_rs1_ex = '0; RU_rs2_ex = '0; imm_ex = '0; alu_a_src_ex = 0; alu_b_src_ex = 0;
    alu_op_ex = '0; rd_ex = '0; dm_ctrl_ex = '0; RU_DM_write_src_ex = '0;
    RUwrite_ex = 0; dm_wr_ex = 0;
    @(negedge clk_ex);
    tick(); tick();
    rst_ex = 0;
    valid_ex = 0;
    tick();
    check("reset_busy", busy_ex, 1'b0);
    check("reset_alu", ALU_res_me, 32'h0);

    issue(5'd0, 32'd5, 32'd7, 1, res, bc, lat);
    check("add_5_7", res, 32'd12);
    check("add_lat", lat, 1);
    check("add_ruwrite", RUwrite_me, 1'b1);
    issue(5'd7, 32'h8000_0000, 32'd4, 0, res, bc, lat);
    check("sra", res, 32'hF800_0000);
    issue(5'd4, 32'd1, 32'hFFFF_FFFF, 0, res, bc, lat);
    check("sltu", res, 32'd1);
    issue(5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, res, bc, lat);
    check("mulhu", res, 32'hFFFF_FFFE);
    issue(5'd16, 32'd100, 32'd7, 0, res, bc, lat);
    check("divu", res, 32'd14);
    check("divu_busy", bc, 33);
    check("divu_lat", lat, 34);
    issue(5'd18, 32'd100, 32'd7, 0, res, bc, lat);
    check("remu", res, 32'd2);
    issue(5'd15, 32'hFFFF_FFF9, 32'd2, 0, res, bc, lat);
    check("div_neg", res, 32'hFFFF_FFFD);
    issue(5'd17, 32'hFFFF_FFF9, 32'd2, 0, res, bc, lat);
    check("rem_neg", res, 32'hFFFF_FFFF);
    issue(5'd15, 32'd5, 32'd0, 0, res, bc, lat);
    check("div_by0", res, 32'hFFFF_FFFF);
    check("div_by0_busy", bc, 1);
    check("div_by0_lat", lat, 2);
    issue(5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, bc, lat);
    check("div_ovf", res, 32'h8000_0000);
    check("div_ovf_busy", bc, 1);
    issue(5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, bc, lat);
    check("rem_ovf", res, 32'h0);

    // Flush on the 10th busy cycle of a divide.
    rand_side();
    valid_ex = 1; flush_ex = 0; RUwrite_ex = 1; alu_op_ex = 5'd16;
    alu_a_src_ex = 0; alu_b_src_ex = 0; RU_rs1_ex = 32'd100; RU_rs2_ex = 32'd7;
    for (int i = 0; i < 9; i++) tick();
    flush_ex = 1;
    tick();
    check("flush_ruwrite", RUwrite_me, 1'b0);
    flush_ex = 0; valid_ex = 0;
    tick();
    check("flush_busy_drop", a_busy, 1'b0);
    issue(5'd1, 32'd10, 32'd3, 0, res, bc, lat);
    check("after_flush_sub", res, 32'd7);

    // Reset in the middle of a divide, then a plain ADD.
    rand_side();
    valid_ex = 1; RUwrite_ex = 1; alu_op_ex = 5'd15;
    alu_a_src_ex = 0; alu_b_src_ex = 0; RU_rs1_ex = 32'd1000; RU_rs2_ex = 32'd3;
    for (int i = 0; i < 6; i++) tick();
    rst_ex = 1;
    tick();
    rst_ex = 0;
    issue(5'd0, 32'd1, 32'd1, 0, res, bc, lat);
    check("rst_add", res, 32'd2);
    check("rst_add_busy", bc, 0);
    check("rst_add_lat", lat, 1);

    // Randomized traffic; ID/EX is held while the model says the stage stalls.
    for (int n = 0; n < 3000; n++) begin
      if (!(m_prev_busy && !prev_flush)) begin
        rand_side();
        valid_ex = ($urandom % 5) != 0;
        alu_op_ex = (($urandom % 4) == 0) ? 5'(15 + $urandom % 4) : 5'($urandom);
        RU_rs1_ex = pick_val(); RU_rs2_ex = pick_val(); imm_ex = pick_val();
        alu_a_src_ex = 1'($urandom); alu_b_src_ex = 1'($urandom);
        RUwrite_ex = 1'($urandom);
      end
      flush_ex = ($urandom % 60) == 0;
      rst_ex = ($urandom % 400) == 0;
      tick();
    end
    rst_ex = 0; flush_ex = 0; valid_ex = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
